// File: rtl/adcalign_mon.sv
// adcalign_mon: frame-alignment search, lock monitor and saturating link counters for one ADC.
// Define ADCALIGN_AUTORELOCK_EN to restart the search automatically on loss of lock.
module adcalign_mon #(
   parameter int NLANE = 8,
   parameter int W = 6,
   parameter logic [W-1:0] FRPAT = 6'b111000,
   parameter int SETTLE = 4,
   parameter int LOCKCNT = 16,
   parameter int LOSSCNT = 4,
   parameter int MAXSLIP = 12,
   parameter int CNTW = 8,
   parameter int SELW = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic [W-1:0] FR,
   input  logic [NLANE*W-1:0] DIN,
   input  logic start,
   input  logic enb,
   input  logic clr,
   output logic BS,
   output logic busy,
   output logic locked,
   output logic fail,
   input  logic [SELW-1:0] rd_sel,
   output logic [CNTW-1:0] rd_dat
);
   localparam int SW = $clog2(MAXSLIP + 1);
   localparam int GW = $clog2(LOCKCNT + 1);
   localparam int BW = $clog2(LOSSCNT + 1);
   localparam int TW = $clog2(SETTLE + 1);
   typedef enum logic [2:0] {IDLE, SLIP, WAIT, CHECK, LOCKED, FAILED} state_t;
`ifdef ADCALIGN_AUTORELOCK_EN
   localparam state_t LOSS = SLIP;
`else
   localparam state_t LOSS = IDLE;
`endif
   state_t st, nx;
   logic [SW-1:0] slip_cnt;
   logic [GW-1:0] good_cnt;
   logic [BW-1:0] bad_cnt;
   logic [TW-1:0] wait_cnt;
   logic [W-1:0] fr_d;
   logic [NLANE*W-1:0] din_d;
   logic [CNTW-1:0] inst [NLANE+1];
   logic [CNTW-1:0] ferr, rd_nx;
   logic [NLANE:0] chg;
   logic match, searching, restart;

   assign match = FR == FRPAT;
   assign searching = st inside {SLIP, WAIT, CHECK};
   assign restart = start && !searching;
   assign chg[0] = FR != fr_d;
   for (genvar i = 0; i < NLANE; i++) begin : g_chg
      assign chg[i+1] = DIN[W*i +: W] != din_d[W*i +: W];
   end

   always_comb begin
      nx = st;
      case (st)
         IDLE, FAILED: nx = start ? CHECK : st;
         SLIP: nx = WAIT;
         WAIT: nx = (wait_cnt == TW'(SETTLE - 1)) ? CHECK : WAIT;
         CHECK: nx = !match ? ((slip_cnt == SW'(MAXSLIP)) ? FAILED : SLIP)
                            : ((good_cnt == GW'(LOCKCNT - 1)) ? LOCKED : CHECK);
         LOCKED: nx = start ? CHECK : (!match && bad_cnt == BW'(LOSSCNT - 1)) ? LOSS : LOCKED;
         default: nx = IDLE;
      endcase
   end

   // outputs are decodes of the state being entered, so they line up with st
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st <= IDLE;
         BS <= 1'b0;
         busy <= 1'b0;
         locked <= 1'b0;
         fail <= 1'b0;
         wait_cnt <= '0;
         good_cnt <= '0;
         bad_cnt <= '0;
         slip_cnt <= '0;
      end else begin
         st <= nx;
         BS <= nx == SLIP;
         busy <= nx inside {SLIP, WAIT, CHECK};
         locked <= nx == LOCKED;
         fail <= nx == FAILED;
         wait_cnt <= (st == WAIT) ? wait_cnt + 1'b1 : '0;
         good_cnt <= (st == CHECK && match) ? good_cnt + 1'b1 : '0;
         bad_cnt <= (nx == LOCKED && !match) ? bad_cnt + 1'b1 : '0;
         slip_cnt <= (restart || (st == LOCKED && nx == SLIP)) ? '0 : (st == SLIP) ? slip_cnt + 1'b1 : slip_cnt;
      end
   end

   for (genvar i = 0; i <= NLANE; i++) begin : g_cnt
      always_ff @(posedge CLK or posedge RST)
         if (RST) inst[i] <= '0;
         else inst[i] <= clr ? '0 : (enb && chg[i] && !(&inst[i])) ? inst[i] + 1'b1 : inst[i];
   end

   assign rd_nx = (rd_sel <= SELW'(NLANE)) ? inst[rd_sel] :
                  (rd_sel == SELW'(NLANE + 1)) ? ferr :
                  (rd_sel == SELW'(NLANE + 2)) ? CNTW'(slip_cnt) : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fr_d <= '0;
         din_d <= '0;
         ferr <= '0;
         rd_dat <= '0;
      end else begin
         fr_d <= FR;
         din_d <= DIN;
         rd_dat <= rd_nx;
         ferr <= clr ? '0 : (enb && st == LOCKED && !match && !(&ferr)) ? ferr + 1'b1 : ferr;
      end
   end
endmodule

// File: tb/tb_adcalign_mon.sv
// tb_adcalign_mon: randomized bench for adcalign_mon against a cycle-level behavioural model.
module tb_adcalign_mon;
   localparam int NLANE = 8;
   localparam int W = 6;
   localparam logic [W-1:0] FRPAT = 6'b111000;
   localparam int SETTLE = 4;
   localparam int LOCKCNT = 16;
   localparam int LOSSCNT = 4;
   localparam int MAXSLIP = 12;
   localparam int CNTW = 8;
   localparam int SELW = 4;
   localparam int CMAX = (1 << CNTW) - 1;
   localparam int S_IDLE = 0, S_SLIP = 1, S_WAIT = 2, S_CHECK = 3, S_LOCK = 4, S_FAIL = 5;

   logic CLK = 1'b0;
   logic RST, start, enb, clr, BS, busy, locked, fail;
   logic [W-1:0] FR;
   logic [NLANE*W-1:0] DIN;
   logic [SELW-1:0] rd_sel;
   logic [CNTW-1:0] rd_dat;

   adcalign_mon #(.NLANE(NLANE), .W(W), .FRPAT(FRPAT), .SETTLE(SETTLE), .LOCKCNT(LOCKCNT),
      .LOSSCNT(LOSSCNT), .MAXSLIP(MAXSLIP), .CNTW(CNTW), .SELW(SELW)) dut (
      .CLK(CLK), .RST(RST), .FR(FR), .DIN(DIN), .start(start), .enb(enb), .clr(clr),
      .BS(BS), .busy(busy), .locked(locked), .fail(fail), .rd_sel(rd_sel), .rd_dat(rd_dat));

   always #5 CLK = ~CLK;

   int checks = 0, failures = 0;
   int n = 0, phase = 0, need = 0;
   int nbs, b1, b2, le;
   bit force_bad = 0, rnd_din = 0;
   int m_st, m_slip, m_good, m_bad, m_wait, m_ferr, m_rd;
   int m_inst [NLANE+1];
   logic [W-1:0] m_frd;
   logic [NLANE*W-1:0] m_dind;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = S_IDLE; m_slip = 0; m_good = 0; m_bad = 0; m_wait = 0; m_ferr = 0; m_rd = 0;
      for (int k = 0; k <= NLANE; k++) m_inst[k] = 0;
      m_frd = '0; m_dind = '0;
   endtask

   task automatic m_restart();
      m_st = S_CHECK; m_slip = 0; m_good = 0; m_bad = 0;
   endtask

   // One clock edge of the controller, derived from the behavioural rules
   task automatic model_step();
      bit mt, c;
      int rd;
      if (RST) begin model_reset(); return; end
      mt = (FR == FRPAT);
      if (rd_sel <= NLANE) rd = m_inst[rd_sel];
      else if (rd_sel == NLANE + 1) rd = m_ferr;
      else if (rd_sel == NLANE + 2) rd = m_slip;
      else rd = 0;
      for (int k = 0; k <= NLANE; k++) begin
         c = (k == 0) ? (FR != m_frd) : (DIN[W*(k-1) +: W] != m_dind[W*(k-1) +: W]);
         if (clr) m_inst[k] = 0;
         else if (enb && c && m_inst[k] < CMAX) m_inst[k]++;
      end
      if (clr) m_ferr = 0;
      else if (enb && m_st == S_LOCK && !mt && m_ferr < CMAX) m_ferr++;
      m_frd = FR; m_dind = DIN; m_rd = rd;
      case (m_st)
         S_IDLE, S_FAIL: if (start) m_restart();
         S_SLIP: begin m_slip++; m_wait = 0; m_st = S_WAIT; end
         S_WAIT: begin m_wait++; if (m_wait == SETTLE) m_st = S_CHECK; end
         S_CHECK:
            if (mt) begin
               m_good++;
               if (m_good == LOCKCNT) begin m_st = S_LOCK; m_bad = 0; end
            end else begin
               m_good = 0;
               m_st = (m_slip == MAXSLIP) ? S_FAIL : S_SLIP;
            end
         S_LOCK:
            if (start) m_restart();
            else if (!mt) begin
               m_bad++;
               if (m_bad == LOSSCNT) begin
                  m_bad = 0; m_good = 0;
`ifdef ADCALIGN_AUTORELOCK_EN
                  m_slip = 0; m_st = S_SLIP;
`else
                  m_st = S_IDLE;
`endif
               end
            end else m_bad = 0;
         default: m_st = S_IDLE;
      endcase
   endtask

   task automatic compare();
      chk("BS", BS, m_st == S_SLIP);
      chk("busy", busy, m_st == S_SLIP || m_st == S_WAIT || m_st == S_CHECK);
      chk("locked", locked, m_st == S_LOCK);
      chk("fail", fail, m_st == S_FAIL);
      chk("rd_dat", rd_dat, m_rd);
   endtask

   task automatic cyc();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      n++;
      compare();
      if (m_st == S_SLIP) phase++;
   endtask

   function automatic logic [W-1:0] bad_word();
      logic [W-1:0] v;
      v = W'($urandom);
      if (v == FRPAT) v = ~FRPAT;
      return v;
   endfunction

   // Receiver stand-in: the frame word lines up once enough bitslips have been applied
   task automatic drive_env();
      FR = (!force_bad && phase >= need) ? FRPAT : bad_word();
      if (rnd_din) for (int i = 0; i < NLANE; i++) DIN[W*i +: W] = W'($urandom);
   endtask

   task automatic toggle3();
      DIN[W*3 +: W] = ~DIN[W*3 +: W];
   endtask

   initial begin
      RST = 1; FR = '0; DIN = '0; start = 0; enb = 0; clr = 0; rd_sel = '0;
      model_reset();
      cyc(); cyc();
      chk("rst_locked", locked, 0);
      chk("rst_rd", rd_dat, 0);
      RST = 0;

      need = 2; rnd_din = 1; enb = 1;
      start = 1; drive_env(); cyc(); start = 0;
      nbs = 0; b1 = 0; b2 = 0;
      for (int i = 0; i < 100 && !locked; i++) begin
         drive_env(); rd_sel = SELW'($urandom_range(0, 15)); cyc();
         if (BS) begin nbs++; if (nbs == 1) b1 = n; else b2 = n; end
      end
      le = n;
      chk("s1_locked", locked, 1);
      chk("s1_bs_count", nbs, 2);
      chk("s1_bs_gap", b2 - b1, 6);
      chk("s1_lock_delay", le - b2, 1 + SETTLE + LOCKCNT);
      rd_sel = SELW'(NLANE + 2); drive_env(); cyc();
      chk("s1_slip_rd", rd_dat, 2);

      need = 1000; start = 1; drive_env(); cyc(); start = 0; nbs = 0;
      for (int i = 0; i < 200 && !fail; i++) begin
         drive_env(); cyc();
         if (BS) nbs++;
      end
      chk("s2_fail", fail, 1);
      chk("s2_busy", busy, 0);
      chk("s2_bs_count", nbs, 12);
      chk("s2_slip_rd", rd_dat, 12);
      need = phase; start = 1; drive_env(); cyc(); start = 0;
      chk("s2_restart_fail", fail, 0);
      chk("s2_restart_busy", busy, 1);
      for (int i = 0; i < 100 && !locked; i++) begin drive_env(); cyc(); end
      chk("s2_relock", locked, 1);

      clr = 1; drive_env(); cyc(); clr = 0; rd_sel = SELW'(NLANE + 1);
      force_bad = 1;
      repeat (3) begin drive_env(); cyc(); end
      force_bad = 0; drive_env(); cyc();
      chk("s3_hold_lock", locked, 1);
      chk("s3_ferr3", rd_dat, 3);
      force_bad = 1;
      repeat (4) begin drive_env(); cyc(); end
      chk("s3_lost", locked, 0);
`ifdef ADCALIGN_AUTORELOCK_EN
      chk("s3_reslip", BS, 1);
`else
      chk("s3_idle", busy, 0);
`endif
      force_bad = 0; drive_env(); cyc();
      chk("s3_ferr7", rd_dat, 7);

      rnd_din = 0;
      for (int i = 0; i < NLANE; i++) DIN[W*i +: W] = W'($urandom);
      clr = 1; drive_env(); cyc(); clr = 0;
      for (int i = 0; i < 300; i++) begin toggle3(); drive_env(); cyc(); end
      rd_sel = 4; cyc(); chk("s4_lane3_sat", rd_dat, 255);
      rd_sel = 1; cyc(); chk("s4_lane0", rd_dat, 0);
      rd_sel = 0; cyc(); chk("s4_frame", rd_dat, 0);
      enb = 0; clr = 1; cyc(); clr = 0;
      repeat (20) begin toggle3(); cyc(); end
      rd_sel = 4; cyc(); chk("s4_enb0", rd_dat, 0);

      enb = 1;
      repeat (3) begin toggle3(); cyc(); end
      cyc(); chk("s5_read3", rd_dat, 3);
      rd_sel = SELW'(NLANE + 3); #1;
      chk("s5_latency_hold", rd_dat, 3);
      cyc(); chk("s5_sel_oob", rd_dat, 0);
      rd_sel = 4; toggle3(); clr = 1; cyc(); clr = 0;
      cyc(); chk("s5_clr_prio", rd_dat, 0);

      rnd_din = 1; rd_sel = 1; need = phase + 5;
      start = 1; drive_env(); cyc(); start = 0;
      for (int i = 0; i < 20 && m_st != S_WAIT; i++) begin drive_env(); cyc(); end
      chk("s6_in_wait", busy, 1);
      RST = 1; #1;
      chk("s6_rst_bs", BS, 0);
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_rd", rd_dat, 0);
      model_reset();
      cyc(); cyc();
      RST = 0; enb = 0;
      for (int i = 0; i < 12; i++) begin rd_sel = SELW'(i); drive_env(); cyc(); end
      chk("s6_stay_idle", busy | locked | fail, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
